req_encoder8: RTL and testbench

//  Counterpart of the team's 2-to-4 enable decoder: takes N request lines and emits their binary indices.

---
 rtl/enc_pkg.sv | 27 ++
 rtl/prio_enc.sv | 16 +
 rtl/req_encoder8.sv | 82 ++++++++
 tb/tb_req_encoder8.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared sizing and encode/decode helpers for the request encoder.
package enc_pkg;

  localparam int unsigned N = 8;
  localparam int unsigned W = $clog2(N);

  // Index of the highest set bit; 0 when no bit is set.
  function automatic logic [W-1:0] prio_idx(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (vec[i]) begin
        idx = W'(i);
      end
    end
    return idx;
  endfunction

  // Decoder direction: binary index to one-hot line.
  function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
    logic [N-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Combinational highest-index-first priority encoder.
module prio_enc
  import enc_pkg::*;
(
  input  logic [N-1:0] in_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  // Encode the highest set bit and flag whether any bit was set.
  always_comb begin
    idx_o   = prio_idx(in_i);
    found_o = |in_i;
  end

endmodule

// File: rtl/req_encoder8.sv
// Request encoder: captures request lines into a sticky pending set and
// drains one binary index per valid/ready handshake, highest index first.
module req_encoder8
  import enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         busy
);

  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] pend_q, pend_d;

  logic         fire;
  logic         load;
  logic [N-1:0] cand;
  logic [W-1:0] cand_idx;
  logic         cand_found;

  // Handshake and candidate set; requests only enter while capture is enabled.
  always_comb begin
    fire = valid_q & out_ready;
    load = ~valid_q | fire;
    cand = pend_q | (en ? req : '0);
  end

  prio_enc u_prio_enc (
    .in_i   (cand),
    .idx_o  (cand_idx),
    .found_o(cand_found)
  );

  // Next-state: load the top candidate when the output slot frees up,
  // otherwise hold the output stable and keep accumulating requests.
  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    if (load) begin
      if (cand_found) begin
        valid_d = 1'b1;
        idx_d   = cand_idx;
        pend_d  = cand & ~onehot(cand_idx);
      end else begin
        // Index is left as-is; out_valid alone marks it stale.
        valid_d = 1'b0;
        pend_d  = '0;
      end
    end else begin
      pend_d = cand;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  // Output drive.
  always_comb begin
    out_valid = valid_q;
    out_idx   = idx_q;
    pending   = pend_q;
    busy      = valid_q | (|pend_q);
  end

endmodule

// File: tb/tb_req_encoder8.sv
// Directed-vector bench for req_encoder8.
module tb_req_encoder8;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic [7:0] pending;
  logic       busy;

  int n_vec;
  int n_bad;

  req_encoder8 dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .pending  (pending),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       rdy;
    logic       valid;
    logic [2:0] idx;
    logic [7:0] pend;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic r, input logic e,
                              input logic [7:0] q, input logic rd, input logic v,
                              input logic [2:0] i, input logic [7:0] p, input logic b);
    vec_t t;
    t.name = name; t.rst = r; t.en = e; t.req = q; t.rdy = rd;
    t.valid = v; t.idx = i; t.pend = p; t.busy = b;
    vecs.push_back(t);
  endfunction

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] q, input logic rd);
    @(negedge clk);
    rst = r; en = e; req = q; out_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic v, input logic [2:0] i,
                       input logic [7:0] p, input logic b);
    n_vec++;
    if (out_valid !== v || out_idx !== i || pending !== p || busy !== b) begin
      n_bad++;
      $display("FAIL %s: got valid=%b idx=%0d pending=%h busy=%b, want valid=%b idx=%0d pending=%h busy=%b",
               name, out_valid, out_idx, pending, busy, v, i, p, b);
    end
  endtask

  task automatic run(input string name, input logic r, input logic e, input logic [7:0] q,
                     input logic rd, input logic v, input logic [2:0] i, input logic [7:0] p,
                     input logic b);
    step(r, e, q, rd);
    check(name, v, i, p, b);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1; en = 1'b0; req = '0; out_ready = 1'b0;

    //   name          rst en req    rdy  valid idx pend   busy
    add("rst0",        1, 0, 8'h00, 0,   0,    0,  8'h00, 0);
    add("rst1",        1, 0, 8'h00, 0,   0,    0,  8'h00, 0);
    // Build pending=0F with an index in flight, then reset mid-stream.
    add("mid_load",    0, 1, 8'h0F, 0,   1,    3,  8'h07, 1);
    add("mid_stall",   0, 1, 8'h08, 0,   1,    3,  8'h0F, 1);
    add("mid_rst0",    1, 1, 8'hFF, 1,   0,    0,  8'h00, 0);
    add("mid_rst1",    1, 1, 8'hFF, 1,   0,    0,  8'h00, 0);
    // Single request, one-cycle latency.
    add("one_grant",   0, 1, 8'h04, 1,   1,    2,  8'h00, 1);
    add("one_idle",    0, 1, 8'h00, 1,   0,    2,  8'h00, 0);
    // Multiple requests drain in descending order.
    add("a1_7",        0, 1, 8'hA1, 1,   1,    7,  8'h21, 1);
    add("a1_5",        0, 1, 8'h00, 1,   1,    5,  8'h01, 1);
    add("a1_0",        0, 1, 8'h00, 1,   1,    0,  8'h00, 1);
    add("a1_idle",     0, 1, 8'h00, 1,   0,    0,  8'h00, 0);
    // Capture disabled masks requests.
    add("en0_a",       0, 0, 8'hFF, 1,   0,    0,  8'h00, 0);
    add("en0_b",       0, 0, 8'hFF, 1,   0,    0,  8'h00, 0);
    add("ff_7",        0, 1, 8'hFF, 1,   1,    7,  8'h7F, 1);
    add("ff_6",        0, 0, 8'hFF, 1,   1,    6,  8'h3F, 1);
    add("ff_5",        0, 0, 8'hFF, 1,   1,    5,  8'h1F, 1);
    add("ff_4",        0, 0, 8'hFF, 1,   1,    4,  8'h0F, 1);
    add("ff_3",        0, 0, 8'hFF, 1,   1,    3,  8'h07, 1);
    add("ff_2",        0, 0, 8'hFF, 1,   1,    2,  8'h03, 1);
    add("ff_1",        0, 0, 8'hFF, 1,   1,    1,  8'h01, 1);
    add("ff_0",        0, 0, 8'hFF, 1,   1,    0,  8'h00, 1);
    add("ff_idle",     0, 0, 8'hFF, 1,   0,    0,  8'h00, 0);
    // Held level is granted every cycle.
    add("lvl_a",       0, 1, 8'h10, 1,   1,    4,  8'h00, 1);
    add("lvl_b",       0, 1, 8'h10, 1,   1,    4,  8'h00, 1);
    add("lvl_idle",    0, 1, 8'h00, 1,   0,    4,  8'h00, 0);

    foreach (vecs[k]) begin
      run(vecs[k].name, vecs[k].rst, vecs[k].en, vecs[k].req, vecs[k].rdy,
          vecs[k].valid, vecs[k].idx, vecs[k].pend, vecs[k].busy);
    end

    // Stall holds the index even when a higher-priority request arrives.
    run("stall_load", 0, 1, 8'h02, 0, 1, 1, 8'h00, 1);
    run("stall_1",    0, 1, 8'h00, 0, 1, 1, 8'h00, 1);
    run("stall_2",    0, 1, 8'h80, 0, 1, 1, 8'h80, 1);
    run("stall_3",    0, 1, 8'h00, 0, 1, 1, 8'h80, 1);
    run("stall_rel",  0, 1, 8'h00, 1, 1, 7, 8'h00, 1);
    run("stall_idle", 0, 1, 8'h00, 1, 0, 7, 8'h00, 0);

    // Re-asserting the in-flight bit re-sets pending: delivered twice.
    run("dup_load",   0, 1, 8'h08, 0, 1, 3, 8'h00, 1);
    run("dup_again",  0, 1, 8'h08, 0, 1, 3, 8'h08, 1);
    run("dup_second", 0, 1, 8'h00, 1, 1, 3, 8'h00, 1);
    run("dup_idle",   0, 1, 8'h00, 1, 0, 3, 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
